// File: rtl/sub_16_serial.sv
// sub_16_serial: 16-bit subtractor d = x - y - b0, evaluated serially one
// 4-bit slice per clock (LSB slice first) with a 4-bit lookahead-carry adder
// computing x_k + ~y_k + ~borrow_k.
//
// Ports:
//   clk        clock, rising-edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand set x, y, b0 presented
//   in_ready   block can accept operands (IDLE only)
//   x, y, b0   minuend, subtrahend, borrow-in
//   out_valid  d and flags valid (DONE only)
//   out_ready  consumer accepts the result
//   d          difference modulo 2^16
//   b16        borrow-out of bit 15
//   ovf        signed overflow
//   zero       d == 0
module sub_16_serial (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        b0,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] d,
  output logic        b16,
  output logic        ovf,
  output logic        zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [1:0]  slice;
  logic [15:0] xr, yr;
  logic        br;

  // Slice datapath signals
  logic [3:0]  na, nb, g, p, c, sum;
  logic        cout;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid) state_nx = RUN;
      RUN:  if (slice == 2'd3) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // 4-bit lookahead adder on the current slice: a + ~b + ~borrow
  always_comb begin
    na   = xr[{slice, 2'b00} +: 4];
    nb   = ~yr[{slice, 2'b00} +: 4];
    g    = na & nb;
    p    = na ^ nb;
    c[0] = ~br;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c[0]);
    cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);
    sum  = p ^ c;
  end

  // Operand capture, slice stepping and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slice <= '0;
      xr    <= '0;
      yr    <= '0;
      br    <= 1'b0;
      d     <= '0;
      b16   <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            xr    <= x;
            yr    <= y;
            br    <= b0;
            slice <= '0;
          end
        end
        RUN: begin
          d[{slice, 2'b00} +: 4] <= sum;
          br    <= ~cout;
          slice <= slice + 2'd1;
          if (slice == 2'd3) begin
            // Flags use the top nibble being written this edge, since d
            // itself only holds it after the edge.
            b16  <= ~cout;
            ovf  <= (xr[15] != yr[15]) & (sum[3] != xr[15]);
            zero <= (d[11:0] == 12'h000) && (sum == 4'h0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_16_serial.sv
module tb_sub_16_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x, y;
  logic        b0;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] d;
  logic        b16, ovf, zero;

  sub_16_serial dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .b0(b0), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .b16(b16), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        b16;
    logic        ovf;
    logic        zero;
    int unsigned acc;
    logic        hold;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: plain 17-bit arithmetic; overflow from operand/result signs
  function automatic exp_t model(input logic [15:0] xv, input logic [15:0] yv,
                                 input logic bv, input int unsigned acc, input logic hold);
    exp_t        e;
    logic [16:0] r;
    r      = {1'b0, xv} - {1'b0, yv} - {16'h0, bv};
    e.d    = r[15:0];
    e.b16  = r[16];
    e.ovf  = (xv[15] != yv[15]) && (r[15] != xv[15]);
    e.zero = (r[15:0] == 16'h0);
    e.acc  = acc;
    e.hold = hold;
    return e;
  endfunction

  // Monitor / consumer
  exp_t        cur;
  logic        active = 1'b0;
  logic        hs_prev = 1'b0;
  int unsigned hold_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      active    = 1'b0;
      hs_prev   = 1'b0;
      out_ready = 1'b0;
    end else begin
      if (hs_prev) begin
        chk("post_hs_out_valid", {31'b0, out_valid}, 32'd0);
        chk("post_hs_in_ready", {31'b0, in_ready}, 32'd1);
      end
      hs_prev = 1'b0;
      if (out_valid) begin
        if (!active) begin
          if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL spurious_out_valid: got 1 expected 0 (t=%0t)", $time);
            cur = model(16'h0, 16'h0, 1'b0, 0, 1'b0);
          end else begin
            cur = exp_q.pop_front();
            chk("latency", cyc, cur.acc + 4);
          end
          active   = 1'b1;
          hold_cnt = cur.hold ? 10 : $urandom_range(0, 3);
        end
        chk("d", {16'h0, d}, {16'h0, cur.d});
        chk("b16", {31'b0, b16}, {31'b0, cur.b16});
        chk("ovf", {31'b0, ovf}, {31'b0, cur.ovf});
        chk("zero", {31'b0, zero}, {31'b0, cur.zero});
        chk("in_ready_done", {31'b0, in_ready}, 32'd0);
        out_ready = (hold_cnt == 0);
        if (hold_cnt > 0) hold_cnt--;
        hs_prev = out_ready;
      end else begin
        active    = 1'b0;
        out_ready = 1'b0;
      end
    end
  end

  // Drive junk while busy; inputs are ignored outside IDLE
  task automatic wait_idle();
    int unsigned w = 0;
    while (!in_ready && w < 300) begin
      in_valid = 1'($urandom);
      x        = 16'($urandom);
      y        = 16'($urandom);
      b0       = 1'($urandom);
      @(negedge clk);
      w++;
    end
    in_valid = 1'b0;
    if (!in_ready) chk("wait_in_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input logic [15:0] xv, input logic [15:0] yv, input logic bv,
                       input logic hold);
    wait_idle();
    if (in_ready) begin
      x = xv; y = yv; b0 = bv; in_valid = 1'b1;
      @(negedge clk);
      exp_q.push_back(model(xv, yv, bv, cyc, hold));
      in_valid = 1'($urandom);
      x        = 16'($urandom);
      y        = 16'($urandom);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_d"}, {16'h0, d}, 32'd0);
    chk({tag, "_flags"}, {29'b0, b16, ovf, zero}, 32'd0);
  endtask

  initial begin
    int unsigned w;
    rst_n = 1'b0; in_valid = 1'b0; x = '0; y = '0; b0 = 1'b0;
    #12;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    issue(16'h1000, 16'h0001, 1'b0, 1'b1);   // long backpressure hold
    issue(16'h0000, 16'h0001, 1'b0, 1'b0);
    issue(16'h8000, 16'h0001, 1'b0, 1'b0);
    issue(16'h7FFF, 16'hFFFF, 1'b0, 1'b0);
    issue(16'h5555, 16'h5554, 1'b1, 1'b0);
    issue(16'h8000, 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 150; i++)
      issue(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom_range(0, 15) == 0));

    // Abort during the second RUN cycle
    wait_idle();
    w = 0;
    while ((exp_q.size() != 0 || out_valid) && w < 400) begin @(negedge clk); w++; end
    x = 16'hFFFF; y = 16'h0001; b0 = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    issue(16'h0003, 16'h0001, 1'b0, 1'b0);
    wait_idle();

    w = 0;
    while ((exp_q.size() != 0 || out_valid) && w < 400) begin @(negedge clk); w++; end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
